// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, frame = 1 start, N data (LSB first),
// optional even parity, M stop bits. Mid-bit sampling from a start edge
// seen on the synchronized line.
//
// Ports:
//   clk        : single clock
//   reset      : synchronous, active-high
//   rx         : asynchronous serial input, idle high
//   data_out   : last received word, held until the next frame completes
//   rx_valid   : one-cycle strobe when data_out / error flags update
//   parity_err : parity mismatch on last frame (0 when PARITY_EN=0)
//   frame_err  : a stop bit was sampled low on last frame
//   busy       : high whenever the receiver is not idle
module uart_rx #(
   parameter int N         = 8,
   parameter int M         = 1,
   parameter int PARITY_EN = 0,
   parameter int BAUD_RATE = 9600,
   parameter int CLK_FREQ  = 50000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rx,
   output logic [N-1:0] data_out,
   output logic         rx_valid,
   output logic         parity_err,
   output logic         frame_err,
   output logic         busy
);

   localparam int CPB  = CLK_FREQ / BAUD_RATE;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam int BMAX = (N > M) ? N : M;
   localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bit_cnt;
   logic [N-1:0]  sreg;
   logic          rx_q1, rx_s;
   logic          armed;
   logic          pe_p, fe_p;

   wire bit_end = (cnt == CW'(CPB - 1));

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         sreg       <= '0;
         rx_q1      <= 1'b1;
         rx_s       <= 1'b1;
         armed      <= 1'b0;
         pe_p       <= 1'b0;
         fe_p       <= 1'b0;
         data_out   <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_q1    <= rx;
         rx_s     <= rx_q1;
         rx_valid <= 1'b0;
         // A high line re-arms start detection; a stuck-low line never does.
         if (rx_s) armed <= 1'b1;

         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_cnt <= '0;
               if (armed && !rx_s) begin
                  state <= START;
                  pe_p  <= 1'b0;
                  fe_p  <= 1'b0;
               end
            end

            START: begin
               if (cnt == CW'(HALF - 1)) begin
                  cnt   <= '0;
                  // Line back high at mid start bit: glitch, drop silently.
                  state <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  cnt  <= '0;
                  // Shift in at the MSB so the first bit ends up in bit 0.
                  sreg <= (sreg >> 1) | (N'(rx_s) << (N - 1));
                  if (bit_cnt == BW'(N - 1)) begin
                     bit_cnt <= '0;
                     state   <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  pe_p  <= rx_s ^ (^sreg);
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_cnt == BW'(M - 1)) begin
                     // Leave at mid stop bit so an immediate next start is caught.
                     state      <= IDLE;
                     bit_cnt    <= '0;
                     data_out   <= sreg;
                     parity_err <= pe_p;
                     frame_err  <= fe_p | ~rx_s;
                     rx_valid   <= 1'b1;
                     // After a framing error, require the line to go high
                     // before another start is accepted.
                     if (fe_p || !rx_s) armed <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (!rx_s) fe_p <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances share clk/reset.
//   u0: N=8 M=1 no parity, u1: N=8 M=1 even parity, u2: N=8 M=2 no parity.
// CLK_FREQ=1e6, BAUD_RATE=1e5 -> 10 clocks per bit.
module tb_uart_rx;

   localparam int CPB = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
   logic [7:0] d0, d1, d2;
   logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;

   int nchecks = 0;
   int nerr = 0;
   int cyc = 0;

   logic [9:0] q0[$], q1[$], q2[$];   // {frame_err, parity_err, data}
   int t0[$], t1[$], t2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.N(8), .M(1), .PARITY_EN(0), .BAUD_RATE(100000), .CLK_FREQ(1000000)) u0 (
      .clk(clk), .reset(reset), .rx(rx0), .data_out(d0), .rx_valid(v0),
      .parity_err(pe0), .frame_err(fe0), .busy(b0));
   uart_rx #(.N(8), .M(1), .PARITY_EN(1), .BAUD_RATE(100000), .CLK_FREQ(1000000)) u1 (
      .clk(clk), .reset(reset), .rx(rx1), .data_out(d1), .rx_valid(v1),
      .parity_err(pe1), .frame_err(fe1), .busy(b1));
   uart_rx #(.N(8), .M(2), .PARITY_EN(0), .BAUD_RATE(100000), .CLK_FREQ(1000000)) u2 (
      .clk(clk), .reset(reset), .rx(rx2), .data_out(d2), .rx_valid(v2),
      .parity_err(pe2), .frame_err(fe2), .busy(b2));

   // Record every strobe with the cycle it was seen on.
   always @(negedge clk) begin
      if (v0) begin q0.push_back({fe0, pe0, d0}); t0.push_back(cyc); end
      if (v1) begin q1.push_back({fe1, pe1, d1}); t1.push_back(cyc); end
      if (v2) begin q2.push_back({fe2, pe2, d2}); t2.push_back(cyc); end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive_bit(input int d, input logic b, input int n);
      case (d)
         0: rx0 = b;
         1: rx1 = b;
         default: rx2 = b;
      endcase
      tick(n);
   endtask

   // Full frame on instance d; parity bit only on u1, second stop only on u2.
   task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                             input logic [1:0] stops);
      drive_bit(d, 1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(d, data[i], CPB);
      if (d == 1) drive_bit(d, pbit, CPB);
      drive_bit(d, stops[0], CPB);
      if (d == 2) drive_bit(d, stops[1], CPB);
   endtask

   // Reference: what the receiver should report for a frame.
   function automatic logic [9:0] model(input int d, input logic [7:0] data,
                                        input logic pbit, input logic [1:0] stops);
      logic fe, pe;
      fe = (d == 2) ? !(stops[0] && stops[1]) : !stops[0];
      pe = (d == 1) ? (pbit != ^data) : 1'b0;
      return {fe, pe, data};
   endfunction

   function automatic int qsize(input int d);
      case (d)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic pull(input int d, output logic [9:0] v, output int c);
      case (d)
         0: begin v = q0.pop_front(); c = t0.pop_front(); end
         1: begin v = q1.pop_front(); c = t1.pop_front(); end
         default: begin v = q2.pop_front(); c = t2.pop_front(); end
      endcase
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(3);
      nchecks++;
      if ({d0, v0, pe0, fe0, b0} !== 12'h000) begin
         nerr++; $display("FAIL reset_u0 got d=%h v=%b pe=%b fe=%b busy=%b exp all 0", d0, v0, pe0, fe0, b0);
      end
      nchecks++;
      if ({d1, v1, pe1, fe1, b1, d2, v2, pe2, fe2, b2} !== 24'h0) begin
         nerr++; $display("FAIL reset_u1u2 got d1=%h d2=%h b1=%b b2=%b exp 0", d1, d2, b1, b2);
      end
      reset = 1'b0;
      tick(5);
   endtask

   task automatic test_basic;
      logic [9:0] v;
      int c;
      fork
         send_frame(0, 8'hA5, 1'b0, 2'b11);
         begin
            tick(3 * CPB);
            nchecks++;
            if (b0 !== 1'b1) begin nerr++; $display("FAIL basic_busy_mid got %b exp 1", b0); end
         end
      join
      tick(2 * CPB);
      nchecks++;
      if (qsize(0) != 1) begin
         nerr++; $display("FAIL basic_count got %0d exp 1", qsize(0));
      end else begin
         pull(0, v, c);
         nchecks++;
         if (v !== model(0, 8'hA5, 1'b0, 2'b11)) begin
            nerr++; $display("FAIL basic_word got %h exp %h", v, model(0, 8'hA5, 1'b0, 2'b11));
         end
      end
      nchecks++;
      if (b0 !== 1'b0) begin nerr++; $display("FAIL basic_busy_after got %b exp 0", b0); end
   endtask

   task automatic test_false_start;
      int k;
      drive_bit(0, 1'b0, 3);
      rx0 = 1'b1;
      k = 0;
      while (b0 !== 1'b1 && k < 8) begin tick(1); k++; end
      k = 0;
      while (b0 !== 1'b0 && k < 8) begin tick(1); k++; end
      nchecks++;
      if (b0 !== 1'b0) begin nerr++; $display("FAIL false_start_busy got %b exp 0 within 8 cycles", b0); end
      tick(3 * CPB);
      nchecks++;
      if (qsize(0) != 0) begin nerr++; $display("FAIL false_start_strobe got %0d exp 0", qsize(0)); end
      nchecks++;
      if (d0 !== 8'hA5) begin nerr++; $display("FAIL false_start_data got %h exp a5", d0); end
   endtask

   task automatic test_parity;
      logic [9:0] v;
      int c;
      send_frame(1, 8'h0F, 1'b1, 2'b11);
      send_frame(1, 8'h07, 1'b1, 2'b11);
      drive_bit(1, 1'b1, 2 * CPB);
      nchecks++;
      if (qsize(1) != 2) begin
         nerr++; $display("FAIL parity_count got %0d exp 2", qsize(1));
      end else begin
         pull(1, v, c);
         nchecks++;
         if (v !== 10'b01_0000_1111) begin nerr++; $display("FAIL parity_bad got %h exp %h", v, 10'b01_0000_1111); end
         pull(1, v, c);
         nchecks++;
         if (v !== 10'b00_0000_0111) begin nerr++; $display("FAIL parity_good got %h exp %h", v, 10'b00_0000_0111); end
      end
   endtask

   task automatic test_frame_err;
      logic [9:0] v;
      int c;
      send_frame(0, 8'h55, 1'b0, 2'b00);
      drive_bit(0, 1'b0, 30);
      nchecks++;
      if (qsize(0) != 1) begin
         nerr++; $display("FAIL frame_err_count got %0d exp 1", qsize(0));
      end else begin
         pull(0, v, c);
         nchecks++;
         if (v !== 10'b10_0101_0101) begin nerr++; $display("FAIL frame_err_word got %h exp %h", v, 10'b10_0101_0101); end
      end
      drive_bit(0, 1'b1, 3 * CPB);
      nchecks++;
      if (qsize(0) != 0) begin nerr++; $display("FAIL frame_err_extra got %0d exp 0", qsize(0)); end
      send_frame(0, 8'h9A, 1'b0, 2'b11);
      drive_bit(0, 1'b1, 2 * CPB);
      nchecks++;
      if (qsize(0) != 1) begin
         nerr++; $display("FAIL frame_err_recover_count got %0d exp 1", qsize(0));
      end else begin
         pull(0, v, c);
         nchecks++;
         if (v !== 10'b00_1001_1010) begin nerr++; $display("FAIL frame_err_recover got %h exp %h", v, 10'b00_1001_1010); end
      end
   endtask

   task automatic test_reset_mid;
      logic [9:0] v;
      int c;
      logic [7:0] w;
      w = 8'hC3;
      drive_bit(0, 1'b0, CPB);
      for (int i = 0; i < 3; i++) drive_bit(0, w[i], CPB);
      drive_bit(0, w[3], 4);
      reset = 1'b1;
      tick(1);
      nchecks++;
      if ({d0, v0, pe0, fe0, b0} !== 12'h000) begin
         nerr++; $display("FAIL reset_mid got d=%h v=%b pe=%b fe=%b busy=%b exp all 0", d0, v0, pe0, fe0, b0);
      end
      reset = 1'b0;
      drive_bit(0, 1'b1, 3 * CPB);
      nchecks++;
      if (qsize(0) != 0) begin nerr++; $display("FAIL reset_mid_strobe got %0d exp 0", qsize(0)); end
      send_frame(0, 8'h3C, 1'b0, 2'b11);
      drive_bit(0, 1'b1, 2 * CPB);
      nchecks++;
      if (qsize(0) != 1) begin
         nerr++; $display("FAIL reset_mid_next_count got %0d exp 1", qsize(0));
      end else begin
         pull(0, v, c);
         nchecks++;
         if (v !== model(0, 8'h3C, 1'b0, 2'b11)) begin nerr++; $display("FAIL reset_mid_next got %h exp %h", v, model(0, 8'h3C, 1'b0, 2'b11)); end
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] va, vb;
      int ca, cb;
      send_frame(2, 8'h01, 1'b0, 2'b11);
      send_frame(2, 8'hFE, 1'b0, 2'b11);
      drive_bit(2, 1'b1, 2 * CPB);
      nchecks++;
      if (qsize(2) != 2) begin
         nerr++; $display("FAIL b2b_count got %0d exp 2", qsize(2));
      end else begin
         pull(2, va, ca);
         pull(2, vb, cb);
         nchecks++;
         if (va !== 10'h001 || vb !== 10'h0FE) begin nerr++; $display("FAIL b2b_words got %h %h exp 001 0fe", va, vb); end
         nchecks++;
         if (cb - ca != 110) begin nerr++; $display("FAIL b2b_spacing got %0d exp 110", cb - ca); end
      end
   endtask

   // Random frames with occasional bad parity / bad stop bits on u1 and u2.
   task automatic test_random(input int d);
      logic [9:0] exp_q[$];
      logic [9:0] v, e;
      logic [7:0] data;
      logic pbit;
      logic [1:0] stops;
      int c, gap;
      for (int n = 0; n < 12; n++) begin
         data = 8'($urandom);
         pbit = ($urandom_range(0, 3) == 0) ? ~(^data) : ^data;
         stops[0] = ($urandom_range(0, 3) != 0);
         stops[1] = ($urandom_range(0, 3) != 0);
         e = model(d, data, pbit, stops);
         exp_q.push_back(e);
         send_frame(d, data, pbit, stops);
         gap = e[9] ? CPB + int'($urandom_range(0, 10)) : int'($urandom_range(0, 15));
         if (gap > 0) drive_bit(d, 1'b1, gap);
      end
      drive_bit(d, 1'b1, 3 * CPB);
      nchecks++;
      if (qsize(d) != exp_q.size()) begin
         nerr++; $display("FAIL random_u%0d_count got %0d exp %0d", d, qsize(d), exp_q.size());
      end else begin
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pull(d, v, c);
            nchecks++;
            if (v !== e) begin nerr++; $display("FAIL random_u%0d_word got %h exp %h", d, v, e); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_parity();
      test_frame_err();
      test_reset_mid();
      test_back_to_back();
      test_random(1);
      test_random(2);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
